// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU control unit.
//   - ALU_* : 4-bit ALU control codes driven on ALUCtrl_o
//   - FN_*  : 10-bit {funct7, funct3} patterns for R-type (ALUOp 10)
//   - F3_*  : funct3 patterns used by I-type, load/store and branch
//   - state_e : control FSM states
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_MUL = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_NOP = 4'b1011;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_DIV = 4'b1101;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [9:0] FN_AND = 10'b0000000_111;
    localparam logic [9:0] FN_OR  = 10'b0000000_110;
    localparam logic [9:0] FN_XOR = 10'b0000000_100;
    localparam logic [9:0] FN_SLL = 10'b0000000_001;
    localparam logic [9:0] FN_SRL = 10'b0000000_101;
    localparam logic [9:0] FN_SRA = 10'b0100000_101;
    localparam logic [9:0] FN_SLT = 10'b0000000_010;
    localparam logic [9:0] FN_ADD = 10'b0000000_000;
    localparam logic [9:0] FN_SUB = 10'b0100000_000;
    localparam logic [9:0] FN_MUL = 10'b0000001_000;
    localparam logic [9:0] FN_DIV = 10'b0000001_100;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational decode of {funct7, funct3} and ALUOp
// into an ALU control code.
//   funct_i   [9:0] : {funct7, funct3}
//   ALUOp_i   [1:0] : 00 load/store, 01 branch, 10 R-type, 11 I-type
//   code_o    [3:0] : ALU control code (NOP when illegal)
//   multi_o         : code is a multi-cycle operation (MUL/DIV)
//   illegal_o       : funct/ALUOp combination is not decodable
module alu_decode
    import alu_pkg::*;
(
    input  logic [9:0] funct_i,
    input  logic [1:0] ALUOp_i,
    output logic [3:0] code_o,
    output logic       multi_o,
    output logic       illegal_o
);

    logic [2:0] funct3;
    assign funct3 = funct_i[2:0];

    always_comb begin
        code_o    = ALU_NOP;
        illegal_o = 1'b0;
        case (ALUOp_i)
            2'b10: begin
                case (funct_i)
                    FN_AND:  code_o = ALU_AND;
                    FN_OR:   code_o = ALU_OR;
                    FN_XOR:  code_o = ALU_XOR;
                    FN_SLL:  code_o = ALU_SLL;
                    FN_SRL:  code_o = ALU_SRL;
                    FN_SRA:  code_o = ALU_SRA;
                    FN_SLT:  code_o = ALU_SLT;
                    FN_ADD:  code_o = ALU_ADD;
                    FN_SUB:  code_o = ALU_SUB;
                    FN_MUL:  code_o = ALU_MUL;
                    FN_DIV:  code_o = ALU_DIV;
                    default: illegal_o = 1'b1;
                endcase
            end
            2'b11: begin
                // Immediate forms ignore funct7 except bit 8 (arithmetic shift).
                case (funct3)
                    F3_ADD:  code_o = ALU_ADD;
                    F3_AND:  code_o = ALU_AND;
                    F3_OR:   code_o = ALU_OR;
                    F3_XOR:  code_o = ALU_XOR;
                    F3_SLL:  code_o = ALU_SLL;
                    F3_SR:   code_o = funct_i[8] ? ALU_SRA : ALU_SRL;
                    default: illegal_o = 1'b1;
                endcase
            end
            2'b00: begin
                case (funct3)
                    F3_LW:   code_o = ALU_ADD;
                    F3_ADD:  code_o = ALU_NOP;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: begin
                // Branches compare by subtraction; other funct3 values are harmless NOPs.
                code_o = (funct3 == F3_ADD) ? ALU_SUB : ALU_NOP;
            end
        endcase
    end

    assign multi_o = (code_o == ALU_MUL) || (code_o == ALU_DIV);

endmodule

// File: rtl/alu_ctrl_mc.sv
// alu_ctrl_mc: registered ALU control unit with multi-cycle MUL/DIV support.
//   clk_i, rst_i (async, active-low)
//   valid_i, funct_i[9:0], ALUOp_i[1:0], flush_i : instruction in
//   ALUCtrl_o[CTRL_W-1:0] : registered control code
//   valid_o   : ALUCtrl_o carries a newly accepted operation
//   stall_o   : multi-cycle operation in progress (BUSY)
//   done_o    : one-cycle pulse when a multi-cycle operation finishes
//   illegal_o : one-cycle pulse when an undecodable operation is accepted
module alu_ctrl_mc
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CTRL_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [9:0]        funct_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              illegal_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] dec_code;
    logic       dec_multi;
    logic       dec_illegal;

    alu_decode u_decode (
        .funct_i   (funct_i),
        .ALUOp_i   (ALUOp_i),
        .code_o    (dec_code),
        .multi_o   (dec_multi),
        .illegal_o (dec_illegal)
    );

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [CTRL_W-1:0]  ctrl_q,    ctrl_d;
    logic               valid_q,   valid_d;
    logic               done_q,    done_d;
    logic               illegal_q, illegal_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (valid_i && !flush_i) begin
                    ctrl_d    = CTRL_W'(dec_code);
                    valid_d   = 1'b1;
                    illegal_d = dec_illegal;
                    // A latency of 1 completes like any single-cycle op.
                    if (dec_multi && (dec_code == ALU_MUL) && (MUL_LAT > 1)) begin
                        state_d = ST_BUSY;
                        cnt_d   = MUL_LOAD;
                    end else if (dec_multi && (dec_code == ALU_DIV) && (DIV_LAT > 1)) begin
                        state_d = ST_BUSY;
                        cnt_d   = DIV_LOAD;
                    end
                end else begin
                    ctrl_d = CTRL_W'(ALU_NOP);
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ctrl_d  = CTRL_W'(ALU_NOP);
                end else if (cnt_q <= CNT_ONE) begin
                    // Also catches a zero count so the counter can never wrap.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= CTRL_W'(ALU_NOP);
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign ALUCtrl_o = ctrl_q;
    assign valid_o   = valid_q;
    assign stall_o   = (state_q == ST_BUSY);
    assign done_o    = done_q;
    assign illegal_o = illegal_q;

endmodule
